// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame
// geometry and the mid-bit offset helper used by the RX and TX sides.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

    // Offset from a bit edge to its centre, in clock cycles.
    function automatic int unsigned uart_half(input int unsigned clks_per_bit);
        return clks_per_bit / 32'd2;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate counter. It counts clock cycles and pulses o_tick for one
// cycle when the count reaches the half-bit or the full-bit terminal
// value. The owner clears it on every state entry and on every tick.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_half,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = uart_half(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart from zero on clear, otherwise advance by one.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_half ? (cnt_q == CNT_W'(HALF - 1))
                           : (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer. Times start, data and stop bits from the
// falling edge of the synchronized line, samples each bit at mid-bit,
// assembles the frame LSB-first and hands the byte to the consumer
// through a valid/read handshake with framing-error and overrun status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 i_Clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic                 i_rx_sig,
    input  logic                 i_rx_fe,
    input  logic                 i_rd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic                 tick_s;
    logic                 clear_s;
    logic                 good_s;
    logic                 bad_s;

    // The counter runs only while a frame is being timed; it restarts on
    // every state change and after every sample so each interval is
    // measured from a known origin.
    assign clear_s = (state_q == ST_IDLE) || (state_d != state_q) || tick_s;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk     (i_Clk),
        .i_reset_n (i_reset_n),
        .i_clear   (clear_s),
        .i_half    (state_q == ST_START),
        .o_tick    (tick_s)
    );

    // Frame sequencing: next state, shift register and bit index.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        good_s  = 1'b0;
        bad_s   = 1'b0;
        if (!i_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_fe) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (!i_rx_sig) begin
                            state_d = ST_DATA;
                            idx_d   = {IDX_W{1'b0}};
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        shift_d = {i_rx_sig, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        // Leave mid-stop-bit so a back-to-back start edge is caught.
                        state_d = ST_IDLE;
                        if (i_rx_sig) begin
                            good_s = 1'b1;
                        end else begin
                            bad_s = 1'b1;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Consumer-facing status: byte delivery, handshake and overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        ferr_d    = bad_s;
        busy_d    = (state_d != ST_IDLE);
        if (good_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !i_rd) begin
                overrun_d = 1'b1;
            end else if (valid_q && i_rd) begin
                // The old byte was taken in the same cycle: no data lost.
                overrun_d = 1'b0;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (i_rd && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d   = valid_q;
            overrun_d = overrun_q;
        end
    end

    // Sequencer registers.
    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= {DATA_BITS{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // Output registers.
    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_q    <= {DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (16 clocks per bit, 8 data bits).
// Expected bytes and frame-error cycles are queued when a frame is driven
// and consumed by a monitor when the receiver reports them.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       i_reset_n;
    logic       i_en;
    logic       i_rx_sig;
    logic       i_rx_fe;
    logic       i_rd;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   ferr_q[$];
    exp_t mon_e;
    int   mon_c;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t0     = 0;

    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (16),
        .DATA_BITS    (8)
    ) dut (
        .i_Clk       (clk),
        .i_reset_n   (i_reset_n),
        .i_en        (i_en),
        .i_rx_sig    (i_rx_sig),
        .i_rx_fe     (i_rx_fe),
        .i_rd        (i_rd),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: during the interval after posedge N, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: new byte delivery and frame-error pulses against the queues.
    always @(negedge clk) begin
        if (o_valid && (!prev_valid || o_data != prev_data)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rx_data", {24'd0, o_data}, {24'd0, mon_e.d});
                chk("rx_latency", cyc, mon_e.cyc);
            end
        end
        if (o_frame_err) begin
            if (ferr_q.size() == 0) begin
                chk("unexpected_frame_err", 32'd1, 32'd0);
            end else begin
                mon_c = ferr_q.pop_front();
                chk("frame_err_cycle", cyc, mon_c);
            end
        end
        prev_valid <= o_valid;
        prev_data  <= o_data;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        i_rx_fe   = 1'b0;
        i_rx_sig  = 1'b1;
        i_rd      = 1'b0;
        i_en      = 1'b1;
        i_reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        set_idle();
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // Drive one frame starting now (t0 = current cycle). Offsets < 0 disable
    // the corresponding event. 'complete' queues the expected outcome.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int n_cyc,
                              input int en_drop_at, input int rst_at, input int rd_at,
                              input bit chk_busy, input bit complete);
        exp_t e;
        t0 = cyc;
        if (complete) begin
            if (stop) begin
                e.d   = d;
                e.cyc = t0 + 153;
                exp_q.push_back(e);
            end else begin
                ferr_q.push_back(t0 + 153);
            end
        end
        for (int off = 0; off < n_cyc; off++) begin
            i_rx_fe   = (off == 0);
            if (off < 16)       i_rx_sig = 1'b0;
            else if (off < 144) i_rx_sig = d[(off - 16) / 16];
            else                i_rx_sig = stop;
            i_en      = !(en_drop_at >= 0 && off >= en_drop_at);
            i_reset_n = !(off == rst_at);
            i_rd      = (off == rd_at);
            @(negedge clk);
            if (chk_busy) begin
                if (off == 0)   chk("busy_t0", {31'd0, o_busy}, 32'd0);
                if (off == 1)   chk("busy_t1", {31'd0, o_busy}, 32'd1);
                if (off == 152) chk("busy_t152", {31'd0, o_busy}, 32'd1);
                if (off == 153) chk("busy_t153", {31'd0, o_busy}, 32'd0);
            end
            if (off == rst_at) begin
                chk("rst_data", {24'd0, o_data}, 32'd0);
                chk("rst_valid", {31'd0, o_valid}, 32'd0);
                chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
                chk("rst_busy", {31'd0, o_busy}, 32'd0);
            end
            next_cycle();
        end
        set_idle();
    endtask

    task automatic read_pulse();
        i_rd = 1'b1;
        next_cycle();
        i_rd = 1'b0;
        @(negedge clk);
        chk("read_valid", {31'd0, o_valid}, 32'd0);
        chk("read_overrun", {31'd0, o_overrun}, 32'd0);
        next_cycle();
    endtask

    initial begin
        set_idle();
        i_reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_data", {24'd0, o_data}, 32'd0);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_ferr", {31'd0, o_frame_err}, 32'd0);
        chk("reset_overrun", {31'd0, o_overrun}, 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        next_cycle();
        idle(4);

        // Good frame 0xA5 with busy window and latency.
        send_frame(8'hA5, 1'b1, 160, -1, -1, -1, 1'b1, 1'b1);
        chk("a5_data", {24'd0, o_data}, 32'h0000_00A5);
        read_pulse();
        idle(4);

        // Glitch: line low three cycles after the edge, then high.
        t0 = cyc;
        for (int off = 0; off < 20; off++) begin
            i_rx_fe  = (off == 0);
            i_rx_sig = (off < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (off == 8) chk("glitch_busy_t8", {31'd0, o_busy}, 32'd1);
            if (off == 9) chk("glitch_busy_t9", {31'd0, o_busy}, 32'd0);
            next_cycle();
        end
        idle(4);

        // Framing error on 0x3C: data and valid untouched.
        send_frame(8'h3C, 1'b0, 160, -1, -1, -1, 1'b0, 1'b1);
        @(negedge clk);
        chk("ferr_valid", {31'd0, o_valid}, 32'd0);
        chk("ferr_data_kept", {24'd0, o_data}, 32'h0000_00A5);
        next_cycle();

        // Overrun: 0x11 then 0x22 unread.
        send_frame(8'h11, 1'b1, 160, -1, -1, -1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 160, -1, -1, -1, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovr_data", {24'd0, o_data}, 32'h0000_0022);
        chk("ovr_valid", {31'd0, o_valid}, 32'd1);
        chk("ovr_overrun", {31'd0, o_overrun}, 32'd1);
        next_cycle();
        read_pulse();
        idle(4);

        // Enable dropped mid-frame at t0+60.
        send_frame(8'h77, 1'b1, 61, 60, -1, -1, 1'b0, 1'b0);
        @(negedge clk);
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_data", {24'd0, o_data}, 32'h0000_0022);
        chk("abort_valid", {31'd0, o_valid}, 32'd0);
        chk("abort_overrun", {31'd0, o_overrun}, 32'd0);
        next_cycle();
        idle(4);
        send_frame(8'h5A, 1'b1, 160, -1, -1, -1, 1'b0, 1'b1);
        idle(4);

        // Reset pulsed mid-frame at t0+60 while 0x5A is still unread.
        send_frame(8'h99, 1'b1, 61, -1, 60, -1, 1'b0, 1'b0);
        idle(4);
        send_frame(8'h5A, 1'b1, 160, -1, -1, -1, 1'b0, 1'b1);
        read_pulse();
        idle(4);

        // Back-to-back with read in the completion cycle of the second.
        send_frame(8'h01, 1'b1, 160, -1, -1, -1, 1'b0, 1'b1);
        send_frame(8'hFE, 1'b1, 160, -1, -1, 152, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_data", {24'd0, o_data}, 32'h0000_00FE);
        chk("b2b_valid", {31'd0, o_valid}, 32'd1);
        chk("b2b_overrun", {31'd0, o_overrun}, 32'd0);
        next_cycle();
        read_pulse();
        idle(4);

        chk("pending_bytes", exp_q.size(), 32'd0);
        chk("pending_ferr", ferr_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
